sgf_align_shifter: RTL and testbench

//  Sequential significand alignment stage of the FP add/subtract datapath, directly downstream of the operand swap mux.

---
 rtl/sgf_align_shifter.sv | 64 ++++++
 tb/tb_sgf_align_shifter.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/sgf_align_shifter.sv
// sgf_align_shifter: iterative right-shift alignment with G/R/S bits and start/done handshake (FAST_ALIGN4_EN enables 4-bit steps)
module sgf_align_shifter #(
    parameter int SW = 24,
    parameter int EW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [EW-1:0] shift_amt_i,
    input  logic [SW-1:0] sgf_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [SW+2:0] sgf_o
);
    localparam int L = SW + 3;
    localparam logic [EW:0] L_AMT = (EW+1)'(L);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state;
    logic [L-1:0] r;
    logic [EW-1:0] cnt;
    assign busy_o = state != IDLE;
    assign done_o = state == DONE;
    assign sgf_o = r;
    // load, shift with sticky accumulation into r[0], and one-cycle done
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            r <= '0;
            cnt <= '0;
        end else begin
            case (state)
                IDLE: if (start_i) begin
                    if ({1'b0, shift_amt_i} >= L_AMT) begin
                        r <= {{(L-1){1'b0}}, |sgf_i};
                        state <= DONE;
                    end else begin
                        r <= {sgf_i, 3'b000};
                        cnt <= shift_amt_i;
                        state <= shift_amt_i == '0 ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
`ifdef FAST_ALIGN4_EN
                    if (cnt >= EW'(4)) begin
                        r <= {4'b0, r[L-1:5], |r[4:0]};
                        cnt <= cnt - EW'(4);
                        state <= cnt == EW'(4) ? DONE : SHIFT;
                    end else begin
                        r <= {1'b0, r[L-1:2], |r[1:0]};
                        cnt <= cnt - EW'(1);
                        state <= cnt == EW'(1) ? DONE : SHIFT;
                    end
`else
                    r <= {1'b0, r[L-1:2], |r[1:0]};
                    cnt <= cnt - EW'(1);
                    state <= cnt == EW'(1) ? DONE : SHIFT;
`endif
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sgf_align_shifter.sv
// tb_sgf_align_shifter: randomized and directed checks of sgf_align_shifter against an arithmetic model
module tb_sgf_align_shifter;
    logic clk = 0, rst = 0, start_i = 0;
    logic [7:0] shift_amt_i = 0;
    logic [23:0] sgf_i = 0;
    logic busy_o, done_o;
    logic [26:0] sgf_o;
    int checks = 0, failures = 0;

    sgf_align_shifter #(.SW(24), .EW(8)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .shift_amt_i(shift_amt_i),
        .sgf_i(sgf_i), .busy_o(busy_o), .done_o(done_o), .sgf_o(sgf_o)
    );

    always #5 clk = ~clk;

    function automatic logic [26:0] model(input logic [23:0] s, input int n);
        logic [26:0] f, lost;
        f = {s, 3'b000};
        if (n >= 27) return {26'b0, |s};
        lost = f & ((27'd1 << n) - 27'd1);
        return (f >> n) | {26'b0, |lost};
    endfunction

    function automatic int lat(input int n);
        if (n >= 27) return 0;
`ifdef FAST_ALIGN4_EN
        return n / 4 + n % 4;
`else
        return n;
`endif
    endfunction

    task automatic wait_done(output int c);
        c = 0;
        @(negedge clk);
        while (!done_o && c < 300) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic do_op(input logic [23:0] s, input logic [7:0] a, input string name);
        int c;
        logic [26:0] e;
        e = model(s, a);
        @(negedge clk);
        start_i = 1; sgf_i = s; shift_amt_i = a;
        @(posedge clk); #1 start_i = 0;
        sgf_i = 24'($urandom);
        wait_done(c);
        checks++;
        if (c !== lat(a)) begin failures++; $display("FAIL %s latency got=%0d exp=%0d", name, c, lat(a)); end
        checks++;
        if (sgf_o !== e) begin failures++; $display("FAIL %s sgf_o got=%h exp=%h", name, sgf_o, e); end
        @(negedge clk);
        checks++;
        if (busy_o !== 0 || done_o !== 0) begin failures++; $display("FAIL %s idle busy=%b done=%b exp 0 0", name, busy_o, done_o); end
        repeat (2) @(negedge clk);
        checks++;
        if (sgf_o !== e) begin failures++; $display("FAIL %s hold got=%h exp=%h", name, sgf_o, e); end
    endtask

    task automatic test_reset;
        do_op(24'h123456, 8'd0, "pre_reset");
        @(posedge clk); #2 rst = 0; #1;
        checks++;
        if (sgf_o !== 0 || busy_o !== 0 || done_o !== 0) begin
            failures++; $display("FAIL reset sgf=%h busy=%b done=%b exp 0 0 0", sgf_o, busy_o, done_o);
        end
        @(negedge clk); rst = 1;
    endtask

    task automatic test_directed;
        do_op(24'h800000, 8'd1, "amt1");
        do_op(24'hC00001, 8'd5, "amt5_sticky");
        do_op(24'h000001, 8'd200, "sat200");
        do_op(24'h000001, 8'd27, "sat27");
        do_op(24'h800000, 8'd26, "amt26");
        do_op(24'hABCDEF, 8'd0, "amt0");
        do_op(24'h000000, 8'd13, "zero13");
        do_op(24'h000000, 8'd255, "zero255");
        do_op(24'h800000, 8'd9, "amt9");
    endtask

    task automatic test_busy_ignore;
        int c;
        logic [26:0] e1, e2;
        e1 = model(24'hC00001, 5);
        e2 = model(24'h0F0F0F, 3);
        @(negedge clk);
        start_i = 1; sgf_i = 24'hC00001; shift_amt_i = 8'd5;
        @(posedge clk); #1 sgf_i = 24'h0F0F0F; shift_amt_i = 8'd3;
        wait_done(c);
        checks++;
        if (c !== lat(5) || sgf_o !== e1) begin failures++; $display("FAIL busy_ignore op1 lat=%0d sgf=%h exp lat=%0d sgf=%h", c, sgf_o, lat(5), e1); end
        @(negedge clk);
        checks++;
        if (busy_o !== 0 || sgf_o !== e1) begin failures++; $display("FAIL busy_ignore after_done busy=%b sgf=%h exp 0 %h", busy_o, sgf_o, e1); end
        @(posedge clk); #1 start_i = 0;
        wait_done(c);
        checks++;
        if (c !== lat(3) || sgf_o !== e2) begin failures++; $display("FAIL busy_ignore op2 lat=%0d sgf=%h exp lat=%0d sgf=%h", c, sgf_o, lat(3), e2); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int seen;
        @(negedge clk);
        start_i = 1; sgf_i = 24'hFFFFFF; shift_amt_i = 8'd9;
        @(posedge clk); #1 start_i = 0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 0; #1;
        checks++;
        if (sgf_o !== 0 || busy_o !== 0 || done_o !== 0) begin
            failures++; $display("FAIL reset_mid sgf=%h busy=%b done=%b exp 0 0 0", sgf_o, busy_o, done_o);
        end
        @(negedge clk); rst = 1;
        seen = 0;
        repeat (15) begin @(negedge clk); if (done_o || busy_o) seen++; end
        checks++;
        if (seen !== 0) begin failures++; $display("FAIL reset_mid activity got=%0d exp=0", seen); end
        do_op(24'h800000, 8'd4, "after_reset");
    endtask

    task automatic test_random;
        logic [7:0] a;
        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 30));
            do_op(24'($urandom) >> $urandom_range(0, 23), a, "random");
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1;
        test_reset;
        test_directed;
        test_busy_ignore;
        test_reset_mid;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
